slave: RTL and testbench
========================

// Module: slave
// PURPOSE
//  I2C target (slave) with a fixed 7-bit address, serving the bus driven by our `master` block.
//  Filters SCL/SDA, detects START/STOP, matches the address and ACKs it, then moves bytes.
//  Reception: delivers bytes to local logic. Transmission: fetches bytes from it.
//  Open-drain only; SDA/SCL are pulled low or released, never driven high.
// PARAMETERS
//  INPUT_CLK_RATE     50000000  clk_in frequency in Hz; must be >= 20x FASTEST_SCL_RATE
//  FASTEST_SCL_RATE   400000    highest supported SCL rate in Hz
//  FILTER_DEPTH       3         consecutive equal samples needed to accept a new SCL/SDA level (1..8)
//  ADDRESS            7'h50     own 7-bit target address
// PORTS
//  clk_in          in     1  system clock
//  rst_n           in     1  asynchronous active-low reset
//  scl             inout  1  open-drain; pulled low only for clock stretching
//  sda             inout  1  open-drain: sda = sda_oe ? 1'b0 : 1'bz
//  addressed       out    1  high from own-address ACK until STOP or any START
//  mode            out    1  R/W bit of the current transaction (1 = master reads)
//  data_rx         out    8  last byte received (write mode)
//  rx_valid        out    1  one-cycle pulse: data_rx updated
//  rx_ack          in     1  1 = ACK the byte just received; sampled at the ACK-slot SCL fall
//  tx_req          out    1  one-cycle pulse: present the next byte on data_tx
//  data_tx         in     8  byte to send; loaded at the SCL fall ending the ACK slot
//  tx_valid        in     1  data_tx is valid; used only with SLAVE_CLOCK_STRETCH_EN
//  nack            out    1  master NACKed the last byte read; cleared at next START
//  stop_detected   out    1  one-cycle pulse on STOP while addressed
// BEHAVIOUR
//  Reset (async, rst_n=0): every output 0, sda/scl released, FSM=IDLE, filters preset to 1.
//   Release is immediate on assertion, including mid-byte.
//  Input path: 2-flop synchronizer, then FILTER_DEPTH-sample glitch filter.
//   Total latency from pin to filtered level is 2+FILTER_DEPTH cycles.
//   Edge pulses are derived from the filtered levels.
//  START = filtered SDA fall while SCL high; STOP = filtered SDA rise while SCL high.
//   Both are accepted in every state and take priority over bit processing in the same cycle.
//   START (incl. repeated): FSM=ADDR, bit count 0, addressed=0, nack=0, sda released.
//   STOP: FSM=IDLE, sda released, addressed=0; stop_detected pulses if addressed was 1.
//  Timing rules: data is sampled on filtered SCL rise. sda_oe changes only on filtered SCL fall.
//  Bits are shifted MSB first; a 4-bit counter counts 0..8 and the 9th bit is the ACK slot.
//  FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
//   ADDR: shift 8 bits.
//    At the 8th SCL fall: if [7:1]==ADDRESS, latch mode=[0], sda_oe=1, go to ADDR_ACK.
//    Otherwise go to WAIT_STOP and never drive.
//   ADDR_ACK: addressed=1 at the ACK-slot SCL rise.
//    If mode=1, tx_req pulses at that rise.
//    At the next SCL fall: mode=0 releases sda and goes to RX_BYTE.
//    mode=1 loads data_tx, drives its MSB and goes to TX_BYTE.
//   RX_BYTE: one cycle after the 8th SCL rise, data_rx updates and rx_valid pulses.
//    At the 8th SCL fall, rx_ack is sampled: 1 sets sda_oe=1 and goes to RX_ACK.
//    0 releases sda and goes to WAIT_STOP.
//   RX_ACK: release sda at the next SCL fall, then return to RX_BYTE.
//   TX_BYTE: sda_oe = ~shift[7] per bit. Release sda at the 8th SCL fall, then go to TX_ACK.
//   TX_ACK: sample SDA at SCL rise. 0 (ACK): tx_req pulses, and at the SCL fall load data_tx and go to TX_BYTE.
//    1 (NACK): nack=1, go to WAIT_STOP.
//   WAIT_STOP: sda released, all bits ignored until START or STOP.
//  A SCL rise/fall with no transaction (IDLE) is ignored. rx_valid and tx_req never pulse in the same cycle.
// CONFIGURATION
//  SLAVE_CLOCK_STRETCH_EN defined: at each TX load point, if tx_valid=0, hold scl low.
//   Release scl in the cycle after tx_valid=1, then load data_tx.
//   Internal stretch timeout: none.
//  Undefined: scl is never driven and tx_valid is ignored.
//   data_tx is loaded unconditionally; local logic must meet the half-period deadline after tx_req.
// TESTING
//  1 Write: master sends 0xA0, 0xB4, STOP, rx_ack=1
//    -> ACK on address and data; one rx_valid with data_rx=8'hB4.
//    -> stop_detected pulses; addressed returns to 0.
//  2 Address 0x52 (byte 0xA4) followed by 3 data bytes
//    -> sda never driven; no rx_valid, tx_req or addressed.
//  3 Read: 0xA1, data_tx=8'hB4, master NACK
//    -> SDA bits 1,0,1,1,0,1,0,0; mode=1; nack=1; FSM WAIT_STOP until STOP.
//  4 Bulk read of 64'hFEEDFACECAFEBEEF, low byte first; master ACKs 7 bytes, NACKs the 8th
//    -> 8 tx_req pulses, bytes EF,BE,FE,CA,CE,FA,ED,FE on SDA, nack only after the 8th.
//  5 Write with rx_ack=0 on the 2nd byte
//    -> ACK slot released; later bytes ignored, no rx_valid; repeated START to 0xA1 re-enters as read.
//  6 rst_n low mid TX_BYTE while sda_oe=1 -> sda released that cycle and all outputs 0.
//    Stretch (with SLAVE_CLOCK_STRETCH_EN): delay tx_valid by 50 cycles -> scl held low for exactly that time.

Source files
------------

// File: rtl/slave.sv
// rtl/slave.sv - I2C target with fixed address, glitch filters and byte-level rx/tx handshakes (option: SLAVE_CLOCK_STRETCH_EN)
module slave #(
  parameter int          INPUT_CLK_RATE   = 50000000,
  parameter int          FASTEST_SCL_RATE = 400000,
  parameter int          FILTER_DEPTH     = 3,
  parameter logic [6:0]  ADDRESS          = 7'h50
) (
  input  logic       clk_in,
  input  logic       rst_n,
  inout  wire        scl,
  inout  wire        sda,
  output logic       addressed,
  output logic       mode,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       tx_req,
  input  logic [7:0] data_tx,
  input  logic       tx_valid,
  output logic       nack,
  output logic       stop_detected
);

  // Reject configurations the filter and sampling scheme cannot honour.
  if (FILTER_DEPTH < 1 || FILTER_DEPTH > 8 || INPUT_CLK_RATE < 20 * FASTEST_SCL_RATE) begin : g_bad_cfg
    $error("slave: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  localparam logic [2:0] FILT_LAST = 3'(FILTER_DEPTH - 1);

  // Index 1 carries SCL, index 0 carries SDA through the input path.
  logic [1:0] sync1, sync2, filt, filt_q;
  logic [2:0] fcnt [2];

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] shift, shift_d;
  logic       sda_oe, sda_oe_d;
  logic       addressed_d, mode_d, rx_valid_d, tx_req_d, nack_d, stop_d;
  logic [7:0] data_rx_d;
  logic       tx_point, load_now;

`ifdef SLAVE_CLOCK_STRETCH_EN
  logic scl_oe, scl_oe_d;
  logic load_wait, load_wait_d;

  assign scl = scl_oe ? 1'b0 : 1'bz;
`else
  logic unused_tx_valid;

  assign unused_tx_valid = tx_valid;
`endif

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronize both pins, then accept a new level only after FILTER_DEPTH equal samples.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= 3'd0;
    end else begin
      sync1  <= {scl, sda};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (fcnt[i] == FILT_LAST) begin
            filt[i] <= sync2[i];
            fcnt[i] <= 3'd0;
          end else begin
            fcnt[i] <= fcnt[i] + 3'd1;
          end
        end else begin
          fcnt[i] <= 3'd0;
        end
      end
    end
  end

  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] & filt_q[1];
  assign start_det = filt_q[0] & ~filt[0] & scl_f & filt_q[1];
  assign stop_det  = ~filt_q[0] & filt[0] & scl_f & filt_q[1];

  // Next-state and datapath decode; START/STOP override any bit event in the same cycle.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shift_d     = shift;
    sda_oe_d    = sda_oe;
    addressed_d = addressed;
    mode_d      = mode;
    data_rx_d   = data_rx;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    nack_d      = nack;
    stop_d      = 1'b0;
    tx_point    = 1'b0;
    load_now    = 1'b0;
`ifdef SLAVE_CLOCK_STRETCH_EN
    scl_oe_d    = scl_oe;
    load_wait_d = load_wait;
`endif
    if (start_det) begin
      state_d     = ADDR;
      cnt_d       = 4'd0;
      addressed_d = 1'b0;
      nack_d      = 1'b0;
      sda_oe_d    = 1'b0;
`ifdef SLAVE_CLOCK_STRETCH_EN
      scl_oe_d    = 1'b0;
      load_wait_d = 1'b0;
`endif
    end else if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_d      = addressed;
`ifdef SLAVE_CLOCK_STRETCH_EN
      scl_oe_d    = 1'b0;
      load_wait_d = 1'b0;
`endif
`ifdef SLAVE_CLOCK_STRETCH_EN
    end else if (load_wait) begin
      if (tx_valid) begin
        scl_oe_d    = 1'b0;
        load_wait_d = 1'b0;
        load_now    = 1'b1;
      end
`endif
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift[6:0], sda_f};
            cnt_d   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_d = 4'd0;
            if (shift[7:1] == ADDRESS) begin
              mode_d   = shift[0];
              sda_oe_d = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            addressed_d = 1'b1;
            tx_req_d    = mode;
          end else if (scl_fall) begin
            if (mode) begin
              tx_point = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = RX_BYTE;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d = {shift[6:0], sda_f};
            cnt_d   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              data_rx_d  = {shift[6:0], sda_f};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_d = 4'd0;
            if (rx_ack) begin
              sda_oe_d = 1'b1;
              state_d  = RX_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WAIT_STOP;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = RX_BYTE;
          end
        end
        TX_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = TX_ACK;
            end else if (cnt != 4'd0) begin
              shift_d  = {shift[6:0], 1'b0};
              sda_oe_d = ~shift[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              tx_req_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = WAIT_STOP;
            end
          end else if (scl_fall) begin
            tx_point = 1'b1;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        IDLE:      sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end

    if (tx_point) begin
`ifdef SLAVE_CLOCK_STRETCH_EN
      if (tx_valid) begin
        load_now = 1'b1;
      end else begin
        sda_oe_d    = 1'b0;
        scl_oe_d    = 1'b1;
        load_wait_d = 1'b1;
      end
`else
      load_now = 1'b1;
`endif
    end

    if (load_now) begin
      shift_d  = data_tx;
      sda_oe_d = ~data_tx[7];
      cnt_d    = 4'd0;
      state_d  = TX_BYTE;
    end
  end

  // State, datapath and output registers; reset releases the bus immediately.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      shift         <= 8'd0;
      sda_oe        <= 1'b0;
      addressed     <= 1'b0;
      mode          <= 1'b0;
      data_rx       <= 8'd0;
      rx_valid      <= 1'b0;
      tx_req        <= 1'b0;
      nack          <= 1'b0;
      stop_detected <= 1'b0;
`ifdef SLAVE_CLOCK_STRETCH_EN
      scl_oe        <= 1'b0;
      load_wait     <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      shift         <= shift_d;
      sda_oe        <= sda_oe_d;
      addressed     <= addressed_d;
      mode          <= mode_d;
      data_rx       <= data_rx_d;
      rx_valid      <= rx_valid_d;
      tx_req        <= tx_req_d;
      nack          <= nack_d;
      stop_detected <= stop_d;
`ifdef SLAVE_CLOCK_STRETCH_EN
      scl_oe        <= scl_oe_d;
      load_wait     <= load_wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_slave.sv
// tb/tb_slave.sv - directed bench for the I2C target: write, foreign address, reads, rx NACK, async reset
`timescale 1ns/1ps
module tb_slave;
  localparam int Q = 20;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       m_scl  = 1'b1;
  logic       m_sda  = 1'b1;
  logic       rx_ack = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] data_tx = 8'h00;
  logic       addressed, mode, rx_valid, tx_req, nack, stop_detected;
  logic [7:0] data_rx;
  wire        scl_w, sda_w;

  assign scl_w = m_scl ? 1'bz : 1'b0;
  assign sda_w = m_sda ? 1'bz : 1'b0;
  pullup (scl_w);
  pullup (sda_w);

  always #5 clk_in = ~clk_in;

  slave dut (
    .clk_in(clk_in), .rst_n(rst_n), .scl(scl_w), .sda(sda_w),
    .addressed(addressed), .mode(mode), .data_rx(data_rx), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .tx_req(tx_req), .data_tx(data_tx), .tx_valid(tx_valid),
    .nack(nack), .stop_detected(stop_detected)
  );

  int compared = 0, mismatched = 0;
  int rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, drive_cnt = 0, addr_cnt = 0, tx_base = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] tx_bytes [0:7];

  // Event monitor and local byte source answering tx_req
  always @(negedge clk_in) begin
    if (rx_valid) begin
      rx_cnt++;
      last_rx = data_rx;
    end
    if (tx_req) begin
      data_tx = tx_bytes[3'(tx_cnt - tx_base)];
      tx_cnt++;
    end
    if (stop_detected) stop_cnt++;
    if (addressed) addr_cnt++;
    if (m_sda && !sda_w) drive_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(Q);
    m_sda = 1'b0; wait_cyc(Q);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(Q);
    m_sda = 1'b1; wait_cyc(Q);
  endtask

  task automatic bit_cycle(input logic b, output logic seen);
    m_sda = b;    wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(Q);
    seen = sda_w; wait_cyc(Q);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(~m_ack, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(5);
    compared++;
    if ({addressed, mode, rx_valid, tx_req, nack, stop_detected, data_rx} !== 14'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b %b %b %b %b %b %h required all 0",
               addressed, mode, rx_valid, tx_req, nack, stop_detected, data_rx);
    end
    compared++;
    if ({scl_w, sda_w} !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_bus: got scl=%b sda=%b required 1 1", scl_w, sda_w);
    end
    rst_n = 1'b1;
    wait_cyc(10);
  endtask

  task automatic test_write();
    int b_rx, b_stop;
    logic ack;
    b_rx = rx_cnt; b_stop = stop_cnt; rx_ack = 1'b1;
    bus_start();
    write_byte(8'hA0, ack);
    compared++;
    if (ack !== 1'b1) begin mismatched++; $display("FAIL write_addr_ack: got %b required 1", ack); end
    compared++;
    if ({addressed, mode} !== 2'b10) begin
      mismatched++; $display("FAIL write_addressed_mode: got %b%b required 10", addressed, mode);
    end
    write_byte(8'hB4, ack);
    compared++;
    if (ack !== 1'b1) begin mismatched++; $display("FAIL write_data_ack: got %b required 1", ack); end
    compared++;
    if (rx_cnt - b_rx !== 1 || last_rx !== 8'hB4) begin
      mismatched++; $display("FAIL write_rx: got %0d pulses data %h required 1 pulse data b4", rx_cnt - b_rx, last_rx);
    end
    bus_stop();
    wait_cyc(10);
    compared++;
    if (stop_cnt - b_stop !== 1 || addressed !== 1'b0) begin
      mismatched++; $display("FAIL write_stop: got %0d pulses addressed %b required 1 pulse addressed 0", stop_cnt - b_stop, addressed);
    end
  endtask

  task automatic test_wrong_address();
    int b_rx, b_tx, b_drv, b_addr;
    logic ack, any_ack;
    logic [7:0] bytes [0:2];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    b_rx = rx_cnt; b_tx = tx_cnt; b_drv = drive_cnt; b_addr = addr_cnt;
    bus_start();
    write_byte(8'hA4, ack);
    any_ack = ack;
    for (int k = 0; k < 3; k++) begin
      write_byte(bytes[k], ack);
      any_ack = any_ack | ack;
    end
    bus_stop();
    wait_cyc(10);
    compared++;
    if (any_ack !== 1'b0) begin mismatched++; $display("FAIL foreign_ack: got %b required 0", any_ack); end
    compared++;
    if (drive_cnt - b_drv !== 0) begin mismatched++; $display("FAIL foreign_drive: got %0d cycles required 0", drive_cnt - b_drv); end
    compared++;
    if ((rx_cnt - b_rx) + (tx_cnt - b_tx) + (addr_cnt - b_addr) !== 0) begin
      mismatched++; $display("FAIL foreign_events: got rx %0d tx %0d addressed %0d required 0 0 0",
                             rx_cnt - b_rx, tx_cnt - b_tx, addr_cnt - b_addr);
    end
  endtask

  task automatic test_read_nack();
    int b_stop;
    logic ack;
    logic [7:0] b;
    tx_bytes[0] = 8'hB4;
    tx_base = tx_cnt; b_stop = stop_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    compared++;
    if (ack !== 1'b1 || mode !== 1'b1) begin
      mismatched++; $display("FAIL read_addr: got ack %b mode %b required 1 1", ack, mode);
    end
    compared++;
    if (tx_cnt - tx_base !== 1) begin mismatched++; $display("FAIL read_tx_req: got %0d required 1", tx_cnt - tx_base); end
    read_byte(1'b0, b);
    compared++;
    if (b !== 8'hB4) begin mismatched++; $display("FAIL read_data: got %h required b4", b); end
    compared++;
    if (nack !== 1'b1) begin mismatched++; $display("FAIL read_nack: got %b required 1", nack); end
    read_byte(1'b0, b);
    compared++;
    if (b !== 8'hFF || tx_cnt - tx_base !== 1) begin
      mismatched++; $display("FAIL read_wait_stop: got %h with %0d tx_req required ff with 1", b, tx_cnt - tx_base);
    end
    bus_stop();
    wait_cyc(10);
    compared++;
    if (nack !== 1'b1 || stop_cnt - b_stop !== 1) begin
      mismatched++; $display("FAIL read_after_stop: got nack %b stops %0d required 1 1", nack, stop_cnt - b_stop);
    end
  endtask

  task automatic test_bulk_read();
    logic [63:0] pattern;
    logic ack;
    logic [7:0] b;
    pattern = 64'hFEEDFACECAFEBEEF;
    for (int k = 0; k < 8; k++) tx_bytes[k] = pattern[8*k +: 8];
    tx_base = tx_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    compared++;
    if (ack !== 1'b1 || nack !== 1'b0) begin
      mismatched++; $display("FAIL bulk_addr: got ack %b nack %b required 1 0", ack, nack);
    end
    for (int k = 0; k < 8; k++) begin
      read_byte(k < 7, b);
      compared++;
      if (b !== pattern[8*k +: 8]) begin
        mismatched++; $display("FAIL bulk_byte%0d: got %h required %h", k, b, pattern[8*k +: 8]);
      end
      compared++;
      if (nack !== (k == 7)) begin
        mismatched++; $display("FAIL bulk_nack%0d: got %b required %b", k, nack, k == 7);
      end
    end
    compared++;
    if (tx_cnt - tx_base !== 8) begin mismatched++; $display("FAIL bulk_tx_req: got %0d required 8", tx_cnt - tx_base); end
    bus_stop();
    wait_cyc(10);
  endtask

  task automatic test_rx_nack_restart();
    int b_rx;
    logic ack;
    logic [7:0] b;
    rx_ack = 1'b1;
    b_rx = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h11, ack);
    compared++;
    if (ack !== 1'b1) begin mismatched++; $display("FAIL rxn_first_ack: got %b required 1", ack); end
    rx_ack = 1'b0;
    write_byte(8'h22, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL rxn_refused_ack: got %b required 0", ack); end
    compared++;
    if (rx_cnt - b_rx !== 2 || last_rx !== 8'h22) begin
      mismatched++; $display("FAIL rxn_second_rx: got %0d pulses data %h required 2 data 22", rx_cnt - b_rx, last_rx);
    end
    write_byte(8'h33, ack);
    compared++;
    if (ack !== 1'b0 || rx_cnt - b_rx !== 2) begin
      mismatched++; $display("FAIL rxn_ignored: got ack %b pulses %0d required 0 2", ack, rx_cnt - b_rx);
    end
    rx_ack = 1'b1;
    tx_bytes[0] = 8'h5A;
    tx_base = tx_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    compared++;
    if (ack !== 1'b1 || mode !== 1'b1 || addressed !== 1'b1) begin
      mismatched++; $display("FAIL rxn_restart: got ack %b mode %b addressed %b required 1 1 1", ack, mode, addressed);
    end
    read_byte(1'b0, b);
    compared++;
    if (b !== 8'h5A) begin mismatched++; $display("FAIL rxn_restart_data: got %h required 5a", b); end
    bus_stop();
    wait_cyc(10);
  endtask

  task automatic test_reset_mid_tx();
    int b_stop;
    logic ack, s, any_one;
    tx_bytes[0] = 8'h00;
    tx_base = tx_cnt;
    b_stop = stop_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    any_one = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bit_cycle(1'b1, s);
      any_one = any_one | s;
    end
    compared++;
    if (any_one !== 1'b0 || sda_w !== 1'b0) begin
      mismatched++; $display("FAIL midtx_driving: got bits_or %b sda %b required 0 0", any_one, sda_w);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (sda_w !== 1'b1) begin mismatched++; $display("FAIL midtx_release: got sda %b required 1", sda_w); end
    compared++;
    if ({addressed, mode, rx_valid, tx_req, nack, stop_detected, data_rx} !== 14'd0) begin
      mismatched++; $display("FAIL midtx_outputs: got %b %b %b %b %b %b %h required all 0",
                             addressed, mode, rx_valid, tx_req, nack, stop_detected, data_rx);
    end
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    bus_stop();
    wait_cyc(10);
    compared++;
    if (stop_cnt - b_stop !== 0) begin mismatched++; $display("FAIL midtx_stop: got %0d pulses required 0", stop_cnt - b_stop); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_address();
    test_read_nack();
    test_bulk_read();
    test_rx_nack_restart();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
